// File: rtl/mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared definitions for the memory-controller read-request generator:
//   - default field widths of a read-access descriptor
//   - packed descriptor layout, MSB->LSB {type, base, offset, size, loop_max},
//     expressed as LSB/MSB positions for the default widths
//   - desc_width(): descriptor width for arbitrary field widths, so that
//     parameterised instances compute their own layout
//   - walker state encoding
// ---------------------------------------------------------------------------
package mem_ctrl_pkg;

  localparam int ADDR_W_DFLT     = 32;
  localparam int TX_SIZE_W_DFLT  = 20;
  localparam int RD_LOOP_W_DFLT  = 10;
  localparam int D_TYPE_W_DFLT   = 2;
  localparam int ROM_ADDR_W_DFLT = 6;

  function automatic int desc_width(input int type_w, input int base_w,
                                    input int off_w, input int size_w,
                                    input int loop_w);
    return type_w + base_w + off_w + size_w + loop_w;
  endfunction

  localparam int ROM_WIDTH = desc_width(D_TYPE_W_DFLT, ADDR_W_DFLT, ADDR_W_DFLT,
                                        TX_SIZE_W_DFLT, RD_LOOP_W_DFLT);

  // Field positions for the default layout
  localparam int LOOP_LSB = 0;
  localparam int LOOP_MSB = LOOP_LSB + RD_LOOP_W_DFLT - 1;
  localparam int SIZE_LSB = LOOP_MSB + 1;
  localparam int SIZE_MSB = SIZE_LSB + TX_SIZE_W_DFLT - 1;
  localparam int OFF_LSB  = SIZE_MSB + 1;
  localparam int OFF_MSB  = OFF_LSB + ADDR_W_DFLT - 1;
  localparam int BASE_LSB = OFF_MSB + 1;
  localparam int BASE_MSB = BASE_LSB + ADDR_W_DFLT - 1;
  localparam int TYPE_LSB = BASE_MSB + 1;
  localparam int TYPE_MSB = TYPE_LSB + D_TYPE_W_DFLT - 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/mem_cfg_ram.sv
// ---------------------------------------------------------------------------
// mem_cfg_ram
// Descriptor table: one write port, one synchronous read port (1-cycle
// latency). Contents are never reset.
// Ports:
//   clk      clock
//   i_we     write enable
//   i_waddr  write index
//   i_wdata  write data
//   i_raddr  read index, sampled every clock
//   o_rdata  registered read data
// ---------------------------------------------------------------------------
module mem_cfg_ram #(
  parameter int AW = 6,
  parameter int DW = 96
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_rd_req_gen.sv
// ---------------------------------------------------------------------------
// mem_rd_req_gen
// Walks a table of read-access descriptors and issues (loop_max+1) strided
// read requests per descriptor to the memory controller, throttled by
// rd_ready. Descriptor MSB->LSB: {type, base, offset, size, loop_max}.
// Ports:
//   clk, resetn    clock, asynchronous active-low reset
//   cfg_wr_en      write one descriptor (ignored while busy)
//   cfg_wr_addr    descriptor index to write
//   cfg_wr_data    packed descriptor
//   cfg_last_idx   index of last valid descriptor, sampled on start
//   start          pulse that begins a table walk (accepted in IDLE only)
//   busy           high from start acceptance until done
//   done           one-cycle pulse after the last request
//   rd_ready       controller accepts a request this cycle
//   rd_req         request issued this cycle
//   rd_addr        request address
//   rd_req_size    request size
//   rd_type        descriptor data type
// ---------------------------------------------------------------------------
module mem_rd_req_gen
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W        = ADDR_W_DFLT,
  parameter int BASE_ADDR_W   = ADDR_W,
  parameter int OFFSET_ADDR_W = ADDR_W,
  parameter int TX_SIZE_WIDTH = TX_SIZE_W_DFLT,
  parameter int RD_LOOP_W     = RD_LOOP_W_DFLT,
  parameter int D_TYPE_W      = D_TYPE_W_DFLT,
  parameter int ROM_ADDR_W    = ROM_ADDR_W_DFLT,
  localparam int ROM_W        = desc_width(D_TYPE_W, BASE_ADDR_W, OFFSET_ADDR_W,
                                           TX_SIZE_WIDTH, RD_LOOP_W)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     cfg_wr_en,
  input  logic [ROM_ADDR_W-1:0]    cfg_wr_addr,
  input  logic [ROM_W-1:0]         cfg_wr_data,
  input  logic [ROM_ADDR_W-1:0]    cfg_last_idx,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  input  logic                     rd_ready,
  output logic                     rd_req,
  output logic [ADDR_W-1:0]        rd_addr,
  output logic [TX_SIZE_WIDTH-1:0] rd_req_size,
  output logic [D_TYPE_W-1:0]      rd_type
);

  localparam int L_SIZE_LSB = RD_LOOP_W;
  localparam int L_OFF_LSB  = L_SIZE_LSB + TX_SIZE_WIDTH;
  localparam int L_BASE_LSB = L_OFF_LSB + OFFSET_ADDR_W;
  localparam int L_TYPE_LSB = L_BASE_LSB + BASE_ADDR_W;

  state_t                   r_state;
  logic                     r_busy;
  logic                     r_done;
  logic [ROM_ADDR_W-1:0]    r_idx;
  logic [ROM_ADDR_W-1:0]    r_last_idx;
  logic [RD_LOOP_W-1:0]     r_count;
  logic [ADDR_W-1:0]        r_acc;
  logic [ADDR_W-1:0]        r_addr;
  logic [TX_SIZE_WIDTH-1:0] r_size;
  logic [D_TYPE_W-1:0]      r_type;

  // Descriptor copy held for the ISSUE phase
  logic [ADDR_W-1:0]        r_base;
  logic [ADDR_W-1:0]        r_offset;
  logic [RD_LOOP_W-1:0]     r_loop_max;

  logic [ROM_W-1:0]         w_rd_data;
  logic                     w_cfg_we;
  logic                     w_fire;
  logic [BASE_ADDR_W-1:0]   w_d_base_raw;
  logic [OFFSET_ADDR_W-1:0] w_d_off_raw;
  logic [ADDR_W-1:0]        w_d_base;
  logic [ADDR_W-1:0]        w_d_offset;
  logic [TX_SIZE_WIDTH-1:0] w_d_size;
  logic [RD_LOOP_W-1:0]     w_d_loop;
  logic [D_TYPE_W-1:0]      w_d_type;
  logic [ADDR_W-1:0]        w_next_acc;

  // Table is frozen for the whole walk so descriptors cannot change under it
  assign w_cfg_we = cfg_wr_en & ~r_busy;

  mem_cfg_ram #(
    .AW (ROM_ADDR_W),
    .DW (ROM_W)
  ) u_cfg_ram (
    .clk     (clk),
    .i_we    (w_cfg_we),
    .i_waddr (cfg_wr_addr),
    .i_wdata (cfg_wr_data),
    .i_raddr (r_idx),
    .o_rdata (w_rd_data)
  );

  assign w_d_loop     = w_rd_data[RD_LOOP_W-1:0];
  assign w_d_size     = w_rd_data[L_SIZE_LSB +: TX_SIZE_WIDTH];
  assign w_d_off_raw  = w_rd_data[L_OFF_LSB  +: OFFSET_ADDR_W];
  assign w_d_base_raw = w_rd_data[L_BASE_LSB +: BASE_ADDR_W];
  assign w_d_type     = w_rd_data[L_TYPE_LSB +: D_TYPE_W];
  assign w_d_base     = ADDR_W'(w_d_base_raw);
  assign w_d_offset   = ADDR_W'(w_d_off_raw);

  // Address arithmetic wraps modulo 2**ADDR_W by construction
  assign w_next_acc = r_acc + r_offset;

  // Combinational from registered state so a reset kills it immediately
  assign w_fire = (r_state == ST_ISSUE) & rd_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_idx      <= '0;
      r_last_idx <= '0;
      r_count    <= '0;
      r_acc      <= '0;
      r_addr     <= '0;
      r_size     <= '0;
      r_type     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_last_idx <= cfg_last_idx;
            r_idx      <= '0;
            r_count    <= '0;
            r_acc      <= '0;
            r_busy     <= 1'b1;
            r_state    <= ST_FETCH;
          end
        end
        // Table read of r_idx is in flight this cycle
        ST_FETCH: r_state <= ST_LOAD;
        ST_LOAD: begin
          r_addr  <= w_d_base;
          r_size  <= w_d_size;
          r_type  <= w_d_type;
          r_state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (w_fire) begin
            if (r_count != r_loop_max) begin
              r_count <= r_count + RD_LOOP_W'(1);
              r_acc   <= w_next_acc;
              r_addr  <= r_base + w_next_acc;
            end else begin
              r_count <= '0;
              r_acc   <= '0;
              if (r_idx == r_last_idx) begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= ST_DONE;
              end else begin
                r_idx   <= r_idx + ROM_ADDR_W'(1);
                r_state <= ST_FETCH;
              end
            end
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Descriptor copy needs no reset: only consumed after a LOAD
  always_ff @(posedge clk) begin
    if (r_state == ST_LOAD) begin
      r_base     <= w_d_base;
      r_offset   <= w_d_offset;
      r_loop_max <= w_d_loop;
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign rd_req      = w_fire;
  assign rd_addr     = r_addr;
  assign rd_req_size = r_size;
  assign rd_type     = r_type;

endmodule

// File: doc/mem_rd_req_gen.md
Name: mem_rd_req_gen

Overview:
- Generates the read-request stream into the 4-AXI memory controller from a small table of access descriptors.
- Each descriptor holds: data type, base address, address stride (offset), transfer size, loop count.
- The block walks the table and issues (loop_max+1) strided read requests per descriptor, throttled by rd_ready.
- Sits directly upstream of the memory controller read path. Its rd_req/rd_addr/rd_req_size outputs are exactly what the controller and its bench checker consume.

Parameters:
- ADDR_W, 32, read address width.
- BASE_ADDR_W, ADDR_W, descriptor base-address field width.
- OFFSET_ADDR_W, ADDR_W, descriptor stride field width.
- TX_SIZE_WIDTH, 20, transfer-size field width.
- RD_LOOP_W, 10, loop-count field width.
- D_TYPE_W, 2, data-type field width.
- ROM_ADDR_W, 6, descriptor-table index width (depth 2**ROM_ADDR_W).

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- cfg_wr_en  in  1  write one descriptor into the table.
- cfg_wr_addr  in  ROM_ADDR_W  descriptor index to write.
- cfg_wr_data  in  ROM_WIDTH  packed descriptor, MSB->LSB: {type, base, offset, size, loop_max}.
- cfg_last_idx  in  ROM_ADDR_W  index of the last valid descriptor; sampled on start.
- start  in  1  single-cycle pulse that begins a table walk.
- busy  out  1  high from the start acceptance until done.
- done  out  1  single-cycle pulse after the last request is issued.
- rd_ready  in  1  controller can accept a request this cycle.
- rd_req  out  1  request issued this cycle.
- rd_addr  out  ADDR_W  request address; valid when rd_req.
- rd_req_size  out  TX_SIZE_WIDTH  request size; valid when rd_req.
- rd_type  out  D_TYPE_W  descriptor type; valid when rd_req.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; busy, done=0.
  - rd_addr, rd_req_size, rd_type, internal index, count and offset accumulator all = 0.
  - Table contents are not cleared.
- IDLE:
  - On start=1, latch cfg_last_idx, set idx=0, count=0, acc=0, busy=1, go to FETCH.
  - start is ignored in every other state.
- FETCH:
  - Table has 1-cycle synchronous read latency; the read address is idx.
  - Next state is LOAD.
- LOAD:
  - Register the descriptor fields.
  - rd_addr <= base; rd_req_size <= size; rd_type <= type.
  - Go to ISSUE.
- ISSUE:
  - rd_req = (state==ISSUE) & rd_ready, combinational from registered state.
  - No request is issued while rd_ready=0. Outputs hold stable.
  - On rd_req with count != loop_max:
    - count++.
    - acc <= acc+offset.
    - rd_addr <= base+acc+offset, truncated to ADDR_W (mod 2**ADDR_W wrap, no error).
  - On rd_req with count == loop_max:
    - count=0, acc=0.
    - If idx==last_idx, go to DONE. Otherwise idx++ and go to FETCH.
- DONE:
  - done=1 for exactly one cycle, busy drops in the same cycle, return to IDLE.
  - A start in that cycle is ignored.
- Timing:
  - Start accepted at edge N gives the first rd_req no earlier than cycle N+3.
  - Between descriptors there is a 2-cycle bubble (FETCH, LOAD).
  - Back-to-back requests within one descriptor occur at 1 per cycle when rd_ready=1.
- Request count per descriptor is loop_max+1. loop_max=0 gives one request.
- size=0 or offset=0 descriptors are issued unmodified.
- cfg_wr_en while busy=1 is dropped. The table must not change mid-walk.
- cfg_wr_en while idle writes the table in one cycle.
- resetn low mid-walk aborts immediately:
  - No done pulse.
  - rd_req drops asynchronously with state.

Decomposition:
- Package mem_ctrl_pkg holds:
  - ROM_WIDTH = D_TYPE_W+BASE_ADDR_W+OFFSET_ADDR_W+TX_SIZE_WIDTH+RD_LOOP_W.
  - Field LSB/MSB position constants for the packed descriptor.
  - State encoding: IDLE, FETCH, LOAD, ISSUE, DONE (3 bits).
- One sub-module, mem_cfg_ram:
  - 1 write port, 1 synchronous-read port.
  - Depth 2**ROM_ADDR_W, width ROM_WIDTH.

Test Plan:
- Single descriptor {type=1, base=0x1000, offset=0x40, size=64, loop_max=3}, rd_ready=1:
  - Required addresses 0x1000, 0x1040, 0x1080, 0x10C0, all with size 64 and type 1.
  - done pulses 1 cycle after the 4th request.
  - First rd_req at start+3.
- Two descriptors (base 0x0 / loop_max 0; base 0x2000 / offset 0x10 / loop_max 1), cfg_last_idx=1:
  - Required sequence 0x0, 0x2000, 0x2010.
  - Exactly 2 idle cycles between the 1st and 2nd requests.
- rd_ready toggled 1,0,0,1,0,1 during the first test:
  - Requests only in rd_ready=1 cycles.
  - rd_addr is held across the stalls.
  - Same 4-address sequence as the first test; no address skipped or duplicated.
- Wrap check, ADDR_W=16, base=0xFFF0, offset=0x20, loop_max=1:
  - Required addresses 0xFFF0 then 0x0010.
- resetn asserted after the 2nd request of the first test:
  - All outputs 0 immediately; no done pulse.
  - A subsequent start replays from 0x1000.
- cfg_wr_en to idx 0 and a second start while busy:
  - Both ignored.
  - Request stream identical to the first test; exactly one done pulse.
